// File: rtl/addsub_if.sv
// addsub_if: request/response bundle between a calculator client and the
// add/sub sequencer.
//   master (client)    : drives start, op_sub, opa, opb, chain, clear;
//                        observes busy, done, result, carry, overflow, acc_valid.
//   slave  (sequencer) : the mirror image.
interface addsub_if;
  logic       start;
  logic       op_sub;
  logic [3:0] opa;
  logic [3:0] opb;
  logic       chain;
  logic       clear;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry;
  logic       overflow;
  logic       acc_valid;

  modport master (
    output start, op_sub, opa, opb, chain, clear,
    input  busy, done, result, carry, overflow, acc_valid
  );

  modport slave (
    input  start, op_sub, opa, opb, chain, clear,
    output busy, done, result, carry, overflow, acc_valid
  );
endinterface

// File: rtl/addsub_sequencer.sv
// addsub_sequencer: sequences one registered 4-bit adder/subtractor datapath.
// It latches a request into dp_a/dp_b/dp_cin, waits LATENCY cycles, captures
// dp_addsub/dp_cout, derives signed 4-bit overflow and keeps the result as
// an accumulator, so the next op can use it as A (chain).
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : start/op_sub/opa/opb/chain/clear in;
//                   busy/done/result/carry/overflow/acc_valid out
//   dp_a/b/cin    : operands to the datapath, held stable while busy
//   dp_addsub/cout: datapath result, valid LATENCY cycles after dp_* settle
// LATENCY legal range 1..15.
module addsub_sequencer #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  addsub_if.slave    bus,
  output logic [3:0] dp_a,
  output logic [3:0] dp_b,
  output logic       dp_cin,
  input  logic [7:0] dp_addsub,
  input  logic       dp_cout
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       ovf_next;
  logic       use_acc;

  // dp_cin doubles as the latched op_sub for the operation in flight.
  always_comb begin
    ovf_next = 1'b0;
    if (dp_cin) ovf_next = (dp_a[3] != dp_b[3]) && (dp_addsub[3] != dp_a[3]);
    else        ovf_next = (dp_a[3] == dp_b[3]) && (dp_addsub[3] != dp_a[3]);
  end

  // A same-cycle clear wipes the accumulator first, so chain falls back to opa.
  assign use_acc = bus.chain && bus.acc_valid && !bus.clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      dp_a          <= '0;
      dp_b          <= '0;
      dp_cin        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.carry     <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.acc_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          if (bus.clear) begin
            bus.acc_valid <= 1'b0;
            bus.result    <= '0;
            bus.carry     <= 1'b0;
            bus.overflow  <= 1'b0;
          end
          if (bus.start) begin
            dp_a     <= use_acc ? bus.result[3:0] : bus.opa;
            dp_b     <= bus.opb;
            dp_cin   <= bus.op_sub;
            cnt      <= 4'(LATENCY);
            bus.busy <= 1'b1;
            state    <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // start and clear are deliberately ignored here; nothing is queued.
          if (cnt == 4'd1) begin
            bus.result    <= dp_addsub;
            bus.carry     <= dp_cout;
            bus.overflow  <= ovf_next;
            bus.acc_valid <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            cnt           <= '0;
            state         <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
module tb_addsub_sequencer;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dp_a, dp_b;
  logic       dp_cin;
  logic [7:0] dp_addsub;
  logic       dp_cout;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  addsub_if bus ();

  addsub_sequencer #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_cin    (dp_cin),
    .dp_addsub (dp_addsub),
    .dp_cout   (dp_cout)
  );

  // Datapath model: combinational a +/- b followed by LAT-1 register stages,
  // so the sum is valid LAT cycles after dp_a/dp_b/dp_cin settle.
  logic [4:0] f, s1, s2;
  assign f = {1'b0, dp_a} + {1'b0, (dp_cin ? ~dp_b : dp_b)} + {4'b0, dp_cin};
  always_ff @(posedge clk) begin
    s1 <= f;
    s2 <= s1;
  end
  assign dp_addsub = {4'b0, s2[3:0]};
  assign dp_cout   = s2[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request; returns in the DONE cycle (done sampled high).
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic sub, input logic ch, input logic clr,
                        input logic [3:0] exp_dpa, input logic [7:0] exp_res,
                        input logic exp_c, input logic exp_ov);
    int k = 0;
    bus.opa = a; bus.opb = b; bus.op_sub = sub; bus.chain = ch;
    bus.clear = clr; bus.start = 1'b1;
    do begin
      tick();
      k++;
      if (k == 1) begin
        bus.start = 1'b0; bus.clear = 1'b0; bus.chain = 1'b0;
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " done_low"}, 32'(bus.done), 32'd0);
        chk({tag, " dp_a"}, 32'(dp_a), 32'(exp_dpa));
        chk({tag, " dp_b"}, 32'(dp_b), 32'(b));
        chk({tag, " dp_cin"}, 32'(dp_cin), 32'(sub));
        if (clr) chk({tag, " acc_cleared"}, 32'(bus.acc_valid), 32'd0);
      end
    end while (!bus.done && k < 20);
    chk({tag, " latency"}, 32'(k), 32'(LAT + 1));
    chk({tag, " result"}, 32'(bus.result), 32'(exp_res));
    chk({tag, " carry"}, 32'(bus.carry), 32'(exp_c));
    chk({tag, " overflow"}, 32'(bus.overflow), 32'(exp_ov));
    chk({tag, " acc_valid"}, 32'(bus.acc_valid), 32'd1);
    chk({tag, " busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    bus.start = 0; bus.op_sub = 0; bus.opa = 0; bus.opb = 0;
    bus.chain = 0; bus.clear = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst result", 32'(bus.result), 32'd0);
    chk("rst acc_valid", 32'(bus.acc_valid), 32'd0);

    // Reset held two cycles in the middle of WAIT.
    bus.opa = 4'h5; bus.opb = 4'h6; bus.op_sub = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("midrst busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    chk("midrst dp", 32'({dp_a, dp_b, dp_cin}), 32'd0);
    chk("midrst acc_valid", 32'(bus.acc_valid), 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done) dones++;
    end
    chk("midrst no_done", 32'(dones), 32'd0);

    // 6 - 3 = 3, carry out set, no overflow.
    run_op("sub6_3", 4'b0110, 4'b0011, 1'b1, 1'b0, 1'b0, 4'b0110, 8'h03, 1'b1, 1'b0);
    tick();
    chk("sub6_3 done_pulse", 32'(bus.done), 32'd0);
    run_op("add7_8", 4'b0111, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b0111, 8'h0F, 1'b0, 1'b0);
    tick();
    run_op("sub7_8", 4'b0111, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b0111, 8'h0F, 1'b0, 1'b1);
    tick();
    run_op("sub8_7", 4'b1000, 4'b0111, 1'b1, 1'b0, 1'b0, 4'b1000, 8'h01, 1'b1, 1'b1);
    tick();

    // Back-to-back: chained request issued in the DONE cycle.
    run_op("add1_1", 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 8'h02, 1'b0, 1'b0);
    run_op("chain", 4'b1111, 4'b0011, 1'b0, 1'b1, 1'b0, 4'b0010, 8'h05, 1'b0, 1'b0);
    tick();

    // start held through WAIT with operands toggling every cycle.
    bus.opa = 4'b0011; bus.opb = 4'b0100; bus.op_sub = 1'b0; bus.start = 1'b1;
    dones = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      bus.opa = ~bus.opa; bus.opb = ~bus.opb;
      chk("hold dp_ab", 32'({dp_a, dp_b}), 32'h34);
      if (bus.done) begin
        dones++;
        bus.start = 1'b0;
        chk("hold result", 32'(bus.result), 32'h07);
      end
    end
    chk("hold one_done", 32'(dones), 32'd1);

    // clear + start + chain: accumulator dropped, opa used.
    run_op("clrstart", 4'b1001, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b1001, 8'h0A, 1'b0, 1'b0);
    tick();

    // clear during WAIT has no effect.
    bus.opa = 4'b0010; bus.opb = 4'b0010; bus.op_sub = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("waitclr acc_valid", 32'(bus.acc_valid), 32'd1);
    chk("waitclr result_kept", 32'(bus.result), 32'h0A);
    dones = 0;
    for (int i = 0; i < 20 && !bus.done; i++) tick();
    chk("waitclr done", 32'(bus.done), 32'd1);
    chk("waitclr result", 32'(bus.result), 32'h04);
    chk("waitclr acc_after", 32'(bus.acc_valid), 32'd1);

    // clear alone zeroes the accumulator.
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr acc_valid", 32'(bus.acc_valid), 32'd0);
    chk("clr result", 32'(bus.result), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
